// File: rtl/fir_interp_dac.sv
// Polyphase interpolating FIR for the DAC transmit path: one time-multiplexed MAC,
// L outputs per input sample, runtime-loadable coefficients, valid/ready on both sides.
module fir_interp_dac #(
  parameter int unsigned TAPS   = 32,
  parameter int unsigned L      = 4,
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 14,
  parameter int unsigned SHIFT  = 14,
  localparam int unsigned AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [WIDTH-1:0]  din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     busy
);

  localparam int unsigned PhaseTaps = TAPS / L;
  localparam int unsigned KWidth    = (PhaseTaps > 1) ? $clog2(PhaseTaps) : 1;
  localparam int unsigned PhWidth   = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned ProdW     = WIDTH + COEF_W;
  localparam int unsigned AccW      = ProdW + $clog2(PhaseTaps);

  localparam logic [KWidth-1:0]  KLast  = KWidth'(PhaseTaps - 1);
  localparam logic [PhWidth-1:0] PhLast = PhWidth'(L - 1);

  localparam logic signed [AccW:0] RoundHalf =
      {{(AccW - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [AccW:0] OutMax = {{(AccW + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [AccW:0] OutMin = {{(AccW + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

  state_e                   state_q;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [WIDTH-1:0]  hist_q [PhaseTaps];
  logic signed [AccW-1:0]   acc_q;
  logic [KWidth-1:0]        k_q;
  logic [PhWidth-1:0]       phase_q;
  logic signed [OUT_W-1:0]  dout_q;
  logic                     dout_valid_q;

  logic [AW-1:0]            coef_idx;
  logic signed [ProdW-1:0]  prod;
  logic signed [AccW-1:0]   acc_d;
  logic signed [AccW:0]     rnd_sum;
  logic signed [AccW:0]     rnd_shr;
  logic signed [OUT_W-1:0]  sat;

  // Phase p, tap k of the polyphase decomposition uses h[k*L + p].
  assign coef_idx = AW'(k_q * L + phase_q);
  assign prod     = coef_q[coef_idx] * hist_q[k_q];
  assign acc_d    = acc_q + {{(AccW - ProdW){prod[ProdW-1]}}, prod};

  // One guard bit keeps the rounding offset from wrapping a near-full accumulator.
  assign rnd_sum  = {acc_q[AccW-1], acc_q} + RoundHalf;
  assign rnd_shr  = rnd_sum >>> SHIFT;

  always_comb begin
    sat = rnd_shr[OUT_W-1:0];
    if (rnd_shr > OutMax) begin
      sat = OutMax[OUT_W-1:0];
    end else if (rnd_shr < OutMin) begin
      sat = OutMin[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      k_q          <= '0;
      phase_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) coef_q[i] <= '0;
      for (int i = 0; i < int'(PhaseTaps); i++) hist_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (coef_we) coef_q[coef_addr] <= coef_wdata;
          if (din_valid) begin
            for (int i = int'(PhaseTaps) - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= din;
            phase_q   <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            state_q   <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == KLast) state_q <= StRound;
        end
        StRound: begin
          dout_q       <= sat;
          dout_valid_q <= 1'b1;
          state_q      <= StOut;
        end
        StOut: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            if (phase_q != PhLast) begin
              phase_q <= phase_q + 1'b1;
              k_q     <= '0;
              acc_q   <= '0;
              state_q <= StMac;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is forced low while reset is held, even though the FSM already sits in idle.
  assign din_ready  = (state_q == StIdle) && n_rst;
  assign busy       = (state_q != StIdle);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
